// File: rtl/game_flow_controller.sv
// Game flow sequencer: IDLE -> INTRO -> PLAY -> CLEAR/DEATH -> ... -> OVER.
// Owns the level number, lives, and the per-level countdown timer.
module game_flow_controller #(
   parameter int INTRO_FRAMES   = 120,
   parameter int CLEAR_FRAMES   = 90,
   parameter int DEATH_FRAMES   = 90,
   parameter int LIVES_INIT     = 3,
   parameter int LEVEL_TIME     = 99,
   parameter int FRAMES_PER_SEC = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       level_done,
   input  logic       hero_hit,
   output logic [2:0] state,
   output logic       play_en,
   output logic       hero_rst,
   output logic       score_clr,
   output logic [9:0] level,
   output logic [2:0] lives,
   output logic [7:0] time_left
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INTRO = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_CLEAR = 3'd3;
   localparam logic [2:0] S_DEATH = 3'd4;
   localparam logic [2:0] S_OVER  = 3'd5;

   localparam logic [15:0] INTRO_LAST = 16'(INTRO_FRAMES - 1);
   localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_FRAMES - 1);
   localparam logic [15:0] DEATH_LAST = 16'(DEATH_FRAMES - 1);
   localparam logic [15:0] SEC_LAST   = 16'(FRAMES_PER_SEC - 1);

   logic [2:0]  state_q, state_d;
   logic [9:0]  level_q, level_d;
   logic [2:0]  lives_q, lives_d;
   logic [7:0]  time_q, time_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] sec_q, sec_d;
   logic        start_q;
   logic        play_en_q, hero_rst_q, score_clr_q;
   logic        score_clr_d;
   logic        press;

   assign press = start_btn & ~start_q;

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      lives_d     = lives_q;
      time_d      = time_q;
      frame_d     = frame_q;
      sec_d       = sec_q;
      score_clr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               state_d     = S_INTRO;
               level_d     = '0;
               lives_d     = 3'(LIVES_INIT);
               score_clr_d = 1'b1;
            end
         end
         S_INTRO: begin
            if (frame_tick) begin
               if (frame_q == INTRO_LAST) state_d = S_PLAY;
               else                       frame_d = frame_q + 16'd1;
            end
         end
         S_PLAY: begin
            // level_done wins over a simultaneous hit or timeout
            if (level_done) begin
               state_d = S_CLEAR;
            end else if (hero_hit || time_q == 8'd0) begin
               state_d = S_DEATH;
            end else if (frame_tick) begin
               if (sec_q == SEC_LAST) begin
                  sec_d  = '0;
                  time_d = (time_q == 8'd0) ? 8'd0 : time_q - 8'd1;
               end else begin
                  sec_d = sec_q + 16'd1;
               end
            end
         end
         S_CLEAR: begin
            if (frame_tick) begin
               if (frame_q == CLEAR_LAST) begin
                  state_d = S_INTRO;
                  level_d = level_q + 10'd1;
               end else begin
                  frame_d = frame_q + 16'd1;
               end
            end
         end
         S_DEATH: begin
            if (frame_tick) begin
               if (frame_q == DEATH_LAST) begin
                  lives_d = lives_q - 3'd1;
                  state_d = (lives_q == 3'd1) ? S_OVER : S_INTRO;
               end else begin
                  frame_d = frame_q + 16'd1;
               end
            end
         end
         S_OVER: begin
            if (press) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A tick coinciding with a transition is dropped by this clear.
      if (state_d != state_q) frame_d = '0;
      if (state_d == S_INTRO && state_q != S_INTRO) begin
         time_d = 8'(LEVEL_TIME);
         sec_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         lives_q     <= '0;
         time_q      <= '0;
         frame_q     <= '0;
         sec_q       <= '0;
         start_q     <= 1'b0;
         play_en_q   <= 1'b0;
         hero_rst_q  <= 1'b0;
         score_clr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         lives_q     <= lives_d;
         time_q      <= time_d;
         frame_q     <= frame_d;
         sec_q       <= sec_d;
         start_q     <= start_btn;
         play_en_q   <= (state_d == S_PLAY);
         hero_rst_q  <= (state_d == S_INTRO) && (state_q != S_INTRO);
         score_clr_q <= score_clr_d;
      end
   end

   assign state     = state_q;
   assign play_en   = play_en_q;
   assign hero_rst  = hero_rst_q;
   assign score_clr = score_clr_q;
   assign level     = level_q;
   assign lives     = lives_q;
   assign time_left = time_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scenario bench for game_flow_controller: expected output snapshots are queued
// as stimulus is applied and compared once the DUT has produced its response.
module tb_game_flow_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       level_done = 1'b0;
   logic       hero_hit = 1'b0;
   logic [2:0] state;
   logic       play_en, hero_rst, score_clr;
   logic [9:0] level;
   logic [2:0] lives;
   logic [7:0] time_left;

   // Snapshot layout: {state, play_en, hero_rst, score_clr, level, lives, time_left}
   logic [26:0] exp_q[$];
   logic [26:0] e;
   int n_checks = 0;
   int n_fail   = 0;

   game_flow_controller dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
      .level_done(level_done), .hero_hit(hero_hit), .state(state), .play_en(play_en),
      .hero_rst(hero_rst), .score_clr(score_clr), .level(level), .lives(lives),
      .time_left(time_left)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [26:0] mk(input logic [2:0] s, input logic pe, input logic hr,
                                      input logic sc, input logic [9:0] lv,
                                      input logic [2:0] li, input logic [7:0] tl);
      return {s, pe, hr, sc, lv, li, tl};
   endfunction

   function automatic logic [26:0] obs();
      return {state, play_en, hero_rst, score_clr, level, lives, time_left};
   endfunction

   // Inputs are driven after a negedge and sampled again at the following negedge.
   task automatic step(input logic ft, input logic ld, input logic hh);
      frame_tick = ft; level_done = ld; hero_hit = hh;
      @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b0; level_done = 1'b0; hero_hit = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      exp_q.push_back(mk(3'd0, 0, 0, 0, 10'd0, 3'd0, 8'd0));
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_start();
      start_btn = 1'b1;
      exp_q.push_back(mk(3'd1, 0, 1, 1, 10'd0, 3'd3, 8'd99));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL start_press: got %h expected %h", obs(), e); end
      exp_q.push_back(mk(3'd1, 0, 0, 0, 10'd0, 3'd3, 8'd99));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL start_held: got %h expected %h", obs(), e); end
      ticks(118);
      exp_q.push_back(mk(3'd1, 0, 0, 0, 10'd0, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL intro_tick119: got %h expected %h", obs(), e); end
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd0, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL intro_to_play: got %h expected %h", obs(), e); end
      start_btn = 1'b0;
   endtask

   task automatic test_level_clear();
      exp_q.push_back(mk(3'd3, 0, 0, 0, 10'd0, 3'd3, 8'd99));
      step(0, 1, 1);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_priority: got %h expected %h", obs(), e); end
      ticks(88);
      exp_q.push_back(mk(3'd3, 0, 0, 0, 10'd0, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_tick89: got %h expected %h", obs(), e); end
      exp_q.push_back(mk(3'd1, 0, 1, 0, 10'd1, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_to_intro: got %h expected %h", obs(), e); end
   endtask

   task automatic test_ignore_outside_play();
      exp_q.push_back(mk(3'd1, 0, 0, 0, 10'd1, 3'd3, 8'd99));
      step(0, 1, 1);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL ignore_in_intro: got %h expected %h", obs(), e); end
   endtask

   task automatic test_timeout();
      ticks(119);
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd1, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL play_level1: got %h expected %h", obs(), e); end
      ticks(59);
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd1, 3'd3, 8'd98));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL first_second: got %h expected %h", obs(), e); end
      ticks(97 * 60 - 1);
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd1, 3'd3, 8'd1));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL time_one: got %h expected %h", obs(), e); end
      ticks(59);
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd1, 3'd3, 8'd0));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL time_zero: got %h expected %h", obs(), e); end
      exp_q.push_back(mk(3'd4, 0, 0, 0, 10'd1, 3'd3, 8'd0));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL timeout_death: got %h expected %h", obs(), e); end
      ticks(89);
      exp_q.push_back(mk(3'd1, 0, 1, 0, 10'd1, 3'd2, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL death_to_intro: got %h expected %h", obs(), e); end
   endtask

   task automatic test_game_over();
      ticks(120);
      exp_q.push_back(mk(3'd4, 0, 0, 0, 10'd1, 3'd2, 8'd99));
      step(0, 0, 1);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL hit_death2: got %h expected %h", obs(), e); end
      ticks(89);
      exp_q.push_back(mk(3'd1, 0, 1, 0, 10'd1, 3'd1, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL last_life_intro: got %h expected %h", obs(), e); end
      ticks(120);
      step(0, 0, 1);
      start_btn = 1'b1;
      ticks(89);
      exp_q.push_back(mk(3'd5, 0, 0, 0, 10'd1, 3'd0, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL game_over: got %h expected %h", obs(), e); end
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      exp_q.push_back(mk(3'd5, 0, 0, 0, 10'd1, 3'd0, 8'd99));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL over_held_btn: got %h expected %h", obs(), e); end
      start_btn = 1'b0;
      step(0, 0, 0);
      start_btn = 1'b1;
      exp_q.push_back(mk(3'd0, 0, 0, 0, 10'd1, 3'd0, 8'd99));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL over_to_idle: got %h expected %h", obs(), e); end
      start_btn = 1'b0;
      step(0, 0, 0);
   endtask

   task automatic test_level_wrap();
      start_btn = 1'b1;
      exp_q.push_back(mk(3'd1, 0, 1, 1, 10'd0, 3'd3, 8'd99));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL restart: got %h expected %h", obs(), e); end
      start_btn = 1'b0;
      ticks(120);
      force dut.level_q = 10'd1023;
      step(0, 0, 0);
      release dut.level_q;
      exp_q.push_back(mk(3'd3, 0, 0, 0, 10'd1023, 3'd3, 8'd99));
      step(0, 1, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_at_1023: got %h expected %h", obs(), e); end
      ticks(89);
      exp_q.push_back(mk(3'd1, 0, 1, 0, 10'd0, 3'd3, 8'd99));
      step(1, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL level_wrap: got %h expected %h", obs(), e); end
   endtask

   task automatic test_reset_mid_play();
      ticks(120);
      ticks(49 * 60);
      exp_q.push_back(mk(3'd2, 1, 0, 0, 10'd0, 3'd3, 8'd50));
      step(0, 0, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL play_time50: got %h expected %h", obs(), e); end
      rst_n = 1'b0;
      exp_q.push_back(mk(3'd0, 0, 0, 0, 10'd0, 3'd0, 8'd0));
      #1;
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL async_reset: got %h expected %h", obs(), e); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(mk(3'd0, 0, 0, 0, 10'd0, 3'd0, 8'd0));
      step(0, 0, 1);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL hit_after_reset: got %h expected %h", obs(), e); end
      exp_q.push_back(mk(3'd0, 0, 0, 0, 10'd0, 3'd0, 8'd0));
      step(1, 1, 0);
      e = exp_q.pop_front(); n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL idle_waits: got %h expected %h", obs(), e); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_level_clear();
      test_ignore_outside_play();
      test_timeout();
      test_game_over();
      test_level_wrap();
      test_reset_mid_play();
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
